// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, BYPASS/IDCODE and user DR capture/update ports.
// Latency: tdo is combinational from the shift registers; capture/update pulses come one tck after their state.
// Backpressure: none, the TAP runs strictly on tck/tms and user DR consumers must accept every pulse.
package jtag_pkg;
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_ctrl_fsm_t;
endpackage

module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH      = 4,
    parameter logic [31:0]         IDCODE_VAL    = 32'h1DEAD0F1,
    parameter logic [IR_WIDTH-1:0] IDCODE_IR     = 4'h1,
    parameter logic [IR_WIDTH-1:0] USER_IR_BASE  = 4'h2,
    parameter int                  NUM_USER_DR   = 2,
    parameter int                  USER_DR_WIDTH = 32
) (
    input  logic                                 tck,
    input  logic                                 trst,
    input  logic                                 tms,
    input  logic                                 tdi,
    output logic                                 tdo,
    output logic                                 tdo_en,
    output logic [3:0]                           tap_state_o,
    output logic [IR_WIDTH-1:0]                  ir_o,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0] udr_rd_data_i,
    output logic [NUM_USER_DR-1:0]               udr_capture_o,
    output logic [USER_DR_WIDTH-1:0]             udr_wr_data_o,
    output logic [NUM_USER_DR-1:0]               udr_update_o
);

    localparam int DR_W = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;

    tap_ctrl_fsm_t state_q, state_d;
    logic [IR_WIDTH-1:0]    ir_q;
    logic [IR_WIDTH-1:0]    ir_sr;
    logic [IR_WIDTH-1:0]    ir_capture;
    logic [DR_W-1:0]        dr_sr;
    logic [DR_W-1:0]        dr_capture;
    logic [DR_W-1:0]        dr_shift;
    logic                   sel_ones;
    logic                   sel_idcode;
    logic [NUM_USER_DR-1:0] user_sel;
    logic                   sel_user;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    // All-ones (BYPASS) takes priority over IDCODE and user opcodes that alias it.
    always_comb begin
        sel_ones   = &ir_q;
        sel_idcode = !sel_ones && (ir_q == IDCODE_IR);
        user_sel   = '0;
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (ir_q == USER_IR_BASE + IR_WIDTH'(k)) begin
                user_sel[k] = 1'b1;
            end
        end
        if (sel_ones || sel_idcode) begin
            user_sel = '0;
        end
        sel_user = |user_sel;
    end

    always_comb begin
        dr_capture = '0;
        if (sel_idcode) begin
            dr_capture[31:0] = IDCODE_VAL;
        end
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (user_sel[k]) begin
                dr_capture[USER_DR_WIDTH-1:0] = udr_rd_data_i[k*USER_DR_WIDTH +: USER_DR_WIDTH];
            end
        end
    end

    // tdi lands at the top of the selected register's length; bits above are don't-care.
    always_comb begin
        dr_shift = dr_sr >> 1;
        if (sel_idcode) begin
            dr_shift[31] = tdi;
        end else if (sel_user) begin
            dr_shift[USER_DR_WIDTH-1] = tdi;
        end else begin
            dr_shift[0] = tdi;
        end
    end

    always_comb begin
        ir_capture    = '0;
        ir_capture[0] = 1'b1;
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_q  <= IDCODE_IR;
            ir_sr <= '0;
            dr_sr <= '0;
        end else begin
            if (state_d == TEST_LOGIC_RESET) begin
                ir_q <= IDCODE_IR;
            end else if (state_q == UPDATE_IR) begin
                ir_q <= ir_sr;
            end
            if (state_q == CAPTURE_IR) begin
                ir_sr <= ir_capture;
            end else if (state_q == SHIFT_IR) begin
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            end
            if (state_q == CAPTURE_DR) begin
                dr_sr <= dr_capture;
            end else if (state_q == SHIFT_DR) begin
                dr_sr <= dr_shift;
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            udr_capture_o <= '0;
            udr_update_o  <= '0;
            udr_wr_data_o <= '0;
        end else begin
            udr_capture_o <= (state_q == CAPTURE_DR) ? user_sel : '0;
            udr_update_o  <= (state_q == UPDATE_DR)  ? user_sel : '0;
            if (state_q == UPDATE_DR && sel_user) begin
                udr_wr_data_o <= dr_sr[USER_DR_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo = ir_sr[0];
        end else if (state_q == SHIFT_DR) begin
            tdo = dr_sr[0];
        end
    end

    assign tdo_en      = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
    assign tap_state_o = state_q;
    assign ir_o        = ir_q;

endmodule
